satatx_frame_arb: RTL
=====================

Name: satatx_frame_arb

Overview:
- Transmit-side frame sequencer and arbiter for the SATA link layer.
- Shares one transmit datapath between two FIS sources: S0 carries command/register FIS, S1 carries data FIS.
- Wraps each granted frame as SOF primitive, payload, CRC-32 and EOF primitive, then waits for the receiver's R_OK/R_ERR before granting again.
- Output feeds the scrambler; words flagged as primitives bypass it.

Parameters:
- SOF_PRIM, 32'h3737B57C, SOF primitive word.
- EOF_PRIM, 32'hD5D5B57C, EOF primitive word.
- CRC_INIT, 32'h52325032, CRC seed loaded at the start of each frame.
- CRC_POLY, 32'h04C11DB7, CRC-32 polynomial.
- LW_TIMEOUT, 16, log2 of the wait-for-status timeout in clocks.

Ports:
- S_AXI_ACLK  in  1  clock.
- S_AXI_ARESET  in  1  synchronous, active-high reset.
- S0_AXIS_TVALID/TREADY/TDATA/TLAST  in/out/in/in  1/1/32/1  source 0 FIS words.
- S1_AXIS_TVALID/TREADY/TDATA/TLAST  in/out/in/in  1/1/32/1  source 1 FIS words.
- M_AXIS_TVALID  out  1  output word valid.
- M_AXIS_TREADY  in  1  downstream ready.
- M_AXIS_TDATA  out  32  output word.
- M_AXIS_TLAST  out  1  last scrambled word of the frame (the CRC word).
- M_AXIS_TPRIM  out  1  word is a primitive and is not to be scrambled.
- i_rok  in  1  one-cycle R_OK received from the far end.
- i_rerr  in  1  one-cycle R_ERR received from the far end.
- o_grant  out  2  one-hot current owner; 0 when idle.
- o_done  out  1  one-cycle pulse when a frame completes.
- o_err  out  1  qualifies o_done: frame failed (R_ERR or timeout).

Behaviour:
- Clock and reset: one clock, S_AXI_ACLK. S_AXI_ARESET is synchronous and active-high.
- Reset values: state=IDLE; M_AXIS_TVALID/TDATA/TLAST/TPRIM=0; S*_TREADY=0; o_grant=0; o_done=o_err=0; crc=CRC_INIT.
- Output register: all M_AXIS_* registered. Loaded only when !M_AXIS_TVALID || M_AXIS_TREADY. Held stable while stalled.
- When M_AXIS_TVALID=0, TDATA/TLAST/TPRIM are 0.
- IDLE:
  - If S0_TVALID, grant S0.
  - Else if S1_TVALID, grant S1.
  - Fixed priority: S0 wins on a simultaneous request.
  - On grant, load crc=CRC_INIT and go to SOF.
- SOF: emit SOF_PRIM with TPRIM=1. On acceptance, go to DATA.
- DATA:
  - Granted source TREADY = (!M_AXIS_TVALID || M_AXIS_TREADY). Non-granted TREADY = 0.
  - Each accepted word: forwarded with 1-cycle latency, TPRIM=0, TLAST=0; crc updated.
  - Word accepted with TLAST=1 moves to CRC.
- CRC: emit the crc value with TPRIM=0, TLAST=1. On acceptance, go to EOF.
- EOF: emit EOF_PRIM with TPRIM=1, TLAST=0. On acceptance, go to WAIT.
- WAIT:
  - Output idle; timeout counter runs.
  - i_rok → o_done=1, o_err=0.
  - i_rerr (including i_rok and i_rerr together) → o_done=1, o_err=1.
  - Counter reaching 2^LW_TIMEOUT-1 → o_done=1, o_err=1.
  - Any of these returns to IDLE with o_grant=0.
  - i_rok/i_rerr outside WAIT are ignored.
- CRC arithmetic: MSB-first, 32 bits per clock. For k=31..0: fb = crc[31]^d[k]; crc = {crc[30:0],1'b0} ^ (fb ? CRC_POLY : 0). No final inversion.
- Ownership: grant is held for the whole frame. The other source stalls regardless of its TVALID.
- Upstream stall in DATA: no output word is produced. The frame stays open with no timeout in DATA.
- One-word payload: SOF, word, CRC, EOF = 4 output words.
- Reset mid-frame: immediate return to IDLE with reset values. No EOF is emitted. The upstream remnant is the source's responsibility.

Optional Feature:
- Macro: SATATX_RR_ARB_EN.
- Defined: round-robin arbitration in IDLE. A last-owner bit is updated on each grant; on a simultaneous request, the source not granted last wins. Last-owner resets to S1, so S0 wins the first tie.
- Undefined: fixed S0 priority as above, with no last-owner state.

Test Plan:
- S0 sends {0x11111111, 0x22222222(TLAST)}, M_TREADY=1 → M words 0x3737B57C(P), 0x11111111, 0x22222222, CRC(TLAST), 0xD5D5B57C(P). CRC equals the software model. o_grant=01. After i_rok, o_done=1 and o_err=0.
- S0 and S1 both valid in IDLE → S0 frame completes, S1 TREADY=0 throughout. After i_rok, S1 is granted. With SATATX_RR_ARB_EN and both valid again after S1 completes, S0 is granted.
- M_TREADY toggled 1,0,0,1 in every state → no word lost or duplicated, TDATA stable while stalled, CRC unchanged versus the no-stall run.
- i_rerr in WAIT → o_done=1 and o_err=1 for one cycle, then IDLE. LW_TIMEOUT=4 with no response → o_done/o_err assert 15 cycles after EOF accept.
- Reset asserted in DATA after 2 payload words → next cycle M_AXIS_TVALID=0, o_grant=0. A new S1 frame then starts with SOF and CRC seeded from 0x52325032.
- One-word S1 payload 0x00000000 → exactly 4 output words, TLAST only on the CRC word.

Source files
------------

// File: rtl/satatx_frame_arb.sv
// SATA link-layer transmit frame sequencer: arbitrates two FIS sources and wraps each frame as SOF, payload, CRC, EOF.
// Optional macro SATATX_RR_ARB_EN selects round-robin arbitration in place of fixed S0 priority.
module satatx_frame_arb #(
    parameter logic [31:0] SOF_PRIM   = 32'h3737B57C,
    parameter logic [31:0] EOF_PRIM   = 32'hD5D5B57C,
    parameter logic [31:0] CRC_INIT   = 32'h52325032,
    parameter logic [31:0] CRC_POLY   = 32'h04C11DB7,
    parameter int          LW_TIMEOUT = 16
) (
    input  logic        S_AXI_ACLK,
    input  logic        S_AXI_ARESET,
    input  logic        S0_AXIS_TVALID,
    output logic        S0_AXIS_TREADY,
    input  logic [31:0] S0_AXIS_TDATA,
    input  logic        S0_AXIS_TLAST,
    input  logic        S1_AXIS_TVALID,
    output logic        S1_AXIS_TREADY,
    input  logic [31:0] S1_AXIS_TDATA,
    input  logic        S1_AXIS_TLAST,
    output logic        M_AXIS_TVALID,
    input  logic        M_AXIS_TREADY,
    output logic [31:0] M_AXIS_TDATA,
    output logic        M_AXIS_TLAST,
    output logic        M_AXIS_TPRIM,
    input  logic        i_rok,
    input  logic        i_rerr,
    output logic [1:0]  o_grant,
    output logic        o_done,
    output logic        o_err,
    output logic [2:0]  o_state
);

    // Handshake: a word moves on any interface only on a clock edge where TVALID and TREADY are
    // both high; a producer holds TVALID and its payload stable until that edge.

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SOF  = 3'd1,
        ST_DATA = 3'd2,
        ST_CRC  = 3'd3,
        ST_EOF  = 3'd4,
        ST_WAIT = 3'd5
    } state_t;

    state_t                  r_state;
    logic                    r_tvalid;
    logic [31:0]             r_tdata;
    logic                    r_tlast;
    logic                    r_tprim;
    logic [1:0]              r_grant;
    logic                    r_done;
    logic                    r_err;
    logic [31:0]             r_crc;
    logic [LW_TIMEOUT-1:0]   r_timer;

    logic                    w_ld;
    logic                    w_data_rdy;
    logic                    w_src_valid;
    logic [31:0]             w_src_data;
    logic                    w_src_last;
    logic                    w_accept;
    logic                    w_req;
    logic                    w_pick_s1;
    logic                    w_timer_max;
    logic                    w_resp;

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [31:0] d);
        logic [31:0] r;
        r = c;
        for (int k = 31; k >= 0; k--) begin
            r = {r[30:0], 1'b0} ^ ((r[31] ^ d[k]) ? CRC_POLY : 32'h0);
        end
        return r;
    endfunction

    // Output register may take a new word when empty or being drained this cycle.
    assign w_ld        = !r_tvalid || M_AXIS_TREADY;
    assign w_data_rdy  = (r_state == ST_DATA) && w_ld && !S_AXI_ARESET;
    assign w_src_valid = r_grant[1] ? S1_AXIS_TVALID : S0_AXIS_TVALID;
    assign w_src_data  = r_grant[1] ? S1_AXIS_TDATA  : S0_AXIS_TDATA;
    assign w_src_last  = r_grant[1] ? S1_AXIS_TLAST  : S0_AXIS_TLAST;
    assign w_accept    = w_data_rdy && w_src_valid;
    assign w_req       = S0_AXIS_TVALID || S1_AXIS_TVALID;
    assign w_timer_max = (r_timer == {LW_TIMEOUT{1'b1}});
    assign w_resp      = i_rok || i_rerr || w_timer_max;

    assign S0_AXIS_TREADY = w_data_rdy && r_grant[0];
    assign S1_AXIS_TREADY = w_data_rdy && r_grant[1];

`ifdef SATATX_RR_ARB_EN
    logic r_last_s1;

    // On a tie the source that did not own the previous frame wins.
    always_comb begin
        w_pick_s1 = 1'b0;
        if (S0_AXIS_TVALID && S1_AXIS_TVALID) begin
            w_pick_s1 = !r_last_s1;
        end else begin
            w_pick_s1 = !S0_AXIS_TVALID && S1_AXIS_TVALID;
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_last_s1 <= 1'b1;
        end else if (r_state == ST_IDLE && w_req) begin
            r_last_s1 <= w_pick_s1;
        end
    end
`else
    assign w_pick_s1 = !S0_AXIS_TVALID;
`endif

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_state  <= ST_IDLE;
            r_tvalid <= 1'b0;
            r_tdata  <= 32'h0;
            r_tlast  <= 1'b0;
            r_tprim  <= 1'b0;
            r_grant  <= 2'b00;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_crc    <= CRC_INIT;
            r_timer  <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_ld) begin
                        r_tvalid <= 1'b0;
                        r_tdata  <= 32'h0;
                        r_tlast  <= 1'b0;
                        r_tprim  <= 1'b0;
                    end
                    if (w_req) begin
                        r_grant <= w_pick_s1 ? 2'b10 : 2'b01;
                        r_crc   <= CRC_INIT;
                        r_state <= ST_SOF;
                    end
                end
                ST_SOF: begin
                    if (w_ld) begin
                        r_tvalid <= 1'b1;
                        r_tdata  <= SOF_PRIM;
                        r_tlast  <= 1'b0;
                        r_tprim  <= 1'b1;
                        r_state  <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_accept) begin
                        r_tvalid <= 1'b1;
                        r_tdata  <= w_src_data;
                        r_tlast  <= 1'b0;
                        r_tprim  <= 1'b0;
                        r_crc    <= crc_step(r_crc, w_src_data);
                        if (w_src_last) begin
                            r_state <= ST_CRC;
                        end
                    end else if (w_ld) begin
                        r_tvalid <= 1'b0;
                        r_tdata  <= 32'h0;
                        r_tlast  <= 1'b0;
                        r_tprim  <= 1'b0;
                    end
                end
                ST_CRC: begin
                    if (w_ld) begin
                        r_tvalid <= 1'b1;
                        r_tdata  <= r_crc;
                        r_tlast  <= 1'b1;
                        r_tprim  <= 1'b0;
                        r_state  <= ST_EOF;
                    end
                end
                ST_EOF: begin
                    if (w_ld) begin
                        r_tvalid <= 1'b1;
                        r_tdata  <= EOF_PRIM;
                        r_tlast  <= 1'b0;
                        r_tprim  <= 1'b1;
                        r_timer  <= '0;
                        r_state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_ld) begin
                        r_tvalid <= 1'b0;
                        r_tdata  <= 32'h0;
                        r_tlast  <= 1'b0;
                        r_tprim  <= 1'b0;
                    end
                    // R_ERR dominates; a timeout only counts as an error when no R_OK arrives with it.
                    if (w_resp) begin
                        r_done  <= 1'b1;
                        r_err   <= !(i_rok && !i_rerr);
                        r_grant <= 2'b00;
                        r_state <= ST_IDLE;
                    end else begin
                        r_timer <= r_timer + {{(LW_TIMEOUT-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign M_AXIS_TVALID = r_tvalid;
    assign M_AXIS_TDATA  = r_tdata;
    assign M_AXIS_TLAST  = r_tlast;
    assign M_AXIS_TPRIM  = r_tprim;
    assign o_grant       = r_grant;
    assign o_done        = r_done;
    assign o_err         = r_err;
    assign o_state       = r_state;

endmodule
